// File: rtl/student_fir_sum_tree_pkg.sv
// rtl/student_fir_sum_tree_pkg.sv - shared types and width helpers for the FIR sum tree
package student_fir_sum_tree_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } collect_state_e;

  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int sum_width(input int in_w, input int n);
    return in_w + clog2_f(n);
  endfunction

  function automatic int tree_levels(input int n);
    return clog2_f(n);
  endfunction

  // Element count entering a given tree level; odd leftovers carry forward.
  function automatic int lanes_at(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Bit offset of a level's data within the flattened stage bus.
  function automatic int stage_offset(input int n, input int w, input int lvl);
    int o;
    o = 0;
    for (int i = 0; i < lvl; i++) o = o + lanes_at(n, i) * w;
    return o;
  endfunction

endpackage

// File: rtl/student_fir_sum_tree_level.sv
// rtl/student_fir_sum_tree_level.sv - one registered pairwise-reduction level of the sum tree
module student_fir_sum_tree_level
  import student_fir_sum_tree_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int W     = 8,
  parameter int N_OUT = (N_IN + 1) / 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  input  logic [N_IN*W-1:0]  data_i,
  output logic               valid_o,
  output logic [N_OUT*W-1:0] data_o
);

  // Operands are pre-extended to the full sum width, so pair sums cannot overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        for (int k = 0; k < N_IN / 2; k++) begin
          data_o[k*W +: W] <= data_i[2*k*W +: W] + data_i[(2*k+1)*W +: W];
        end
        if (N_IN % 2 == 1) begin
          data_o[(N_OUT-1)*W +: W] <= data_i[(N_IN-1)*W +: W];
        end
      end
    end
  end

endmodule

// File: rtl/student_fir_sum_tree.sv
// rtl/student_fir_sum_tree.sv - FIR partial-sum collector, adder tree and round/shift/saturate stage
module student_fir_sum_tree
  import student_fir_sum_tree_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int TIMEOUT   = 1023
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_IN-1:0]          lane_valid_i,
  input  logic [NUM_IN*IN_WIDTH-1:0] lane_data_i,
  input  logic [4:0]                 shift_i,
  input  logic                       round_en_i,
  input  logic                       sat_en_i,
  input  logic                       clear_i,
  output logic                       y_valid_o,
  output logic [OUT_WIDTH-1:0]       y_o,
  output logic                       ovf_o,
  output logic                       lane_err_o,
  output logic                       busy_o
);

  localparam int SUM_W   = sum_width(IN_WIDTH, NUM_IN);
  localparam int L       = tree_levels(NUM_IN);
  localparam int BUS_W   = stage_offset(NUM_IN, SUM_W, L + 1);
  localparam int SUM_OFF = stage_offset(NUM_IN, SUM_W, L);
  localparam int EXT_W   = SUM_W + 1;
  localparam int CMP_W   = (EXT_W > OUT_WIDTH) ? EXT_W : OUT_WIDTH;
  localparam int MAX_SH  = SUM_W - 1;
  localparam int CNT_W   = (TIMEOUT < 2) ? 1 : clog2_f(TIMEOUT);

  localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic signed [CMP_W-1:0]     CMP_MAX  = SAT_MAX;
  localparam logic signed [CMP_W-1:0]     CMP_MIN  = SAT_MIN;

  collect_state_e             state_q, state_d;
  logic [NUM_IN-1:0]          pending_q, pending_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_IN*IN_WIDTH-1:0] hold_q;
  logic [NUM_IN-1:0]          capture, dup;
  logic                       complete, timeout_hit, err_set;
  logic [NUM_IN*SUM_W-1:0]    launch_d, launch_data_q;
  logic                       launch_valid_q;

  logic [BUS_W-1:0]           stage_data;
  logic [L:0]                 stage_valid;

  logic signed [SUM_W-1:0]    tree_sum;
  logic                       tree_valid;
  logic [5:0]                 shamt;
  logic signed [EXT_W-1:0]    ext, rnd, shifted;
  logic signed [CMP_W-1:0]    wide;
  logic                       ovf_hit;
  logic [OUT_WIDTH-1:0]       y_next;

  assign capture     = lane_valid_i & ~pending_q;
  assign dup         = lane_valid_i & pending_q;
  assign complete    = &(pending_q | lane_valid_i);
  assign timeout_hit = (state_q == S_COLLECT) && (cnt_q == CNT_LAST);
  assign busy_o      = (state_q == S_COLLECT);

  // Clear beats every error source but never blocks a completing frame's launch.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    err_set   = 1'b0;
    if (clear_i) begin
      state_d   = S_IDLE;
      pending_d = '0;
      cnt_d     = '0;
    end else if (complete) begin
      state_d   = S_IDLE;
      pending_d = '0;
      cnt_d     = '0;
      err_set   = |dup;
    end else if (timeout_hit) begin
      state_d   = S_IDLE;
      pending_d = '0;
      cnt_d     = '0;
      err_set   = 1'b1;
    end else begin
      pending_d = pending_q | lane_valid_i;
      state_d   = (|pending_d) ? S_COLLECT : S_IDLE;
      cnt_d     = (state_q == S_COLLECT) ? cnt_q + CNT_W'(1) : '0;
      err_set   = |dup;
    end
  end

  always_comb begin
    launch_d = '0;
    for (int n = 0; n < NUM_IN; n++) begin
      launch_d[n*SUM_W +: SUM_W] = capture[n]
        ? SUM_W'($signed(lane_data_i[n*IN_WIDTH +: IN_WIDTH]))
        : SUM_W'($signed(hold_q[n*IN_WIDTH +: IN_WIDTH]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q         <= '0;
      lane_err_o     <= 1'b0;
      launch_valid_q <= 1'b0;
      launch_data_q  <= '0;
    end else begin
      for (int n = 0; n < NUM_IN; n++) begin
        if (capture[n]) hold_q[n*IN_WIDTH +: IN_WIDTH] <= lane_data_i[n*IN_WIDTH +: IN_WIDTH];
      end
      if (clear_i)      lane_err_o <= 1'b0;
      else if (err_set) lane_err_o <= 1'b1;
      launch_valid_q <= complete;
      if (complete) launch_data_q <= launch_d;
    end
  end

  assign stage_data[NUM_IN*SUM_W-1:0] = launch_data_q;
  assign stage_valid[0]               = launch_valid_q;

  for (genvar i = 0; i < L; i++) begin : g_level
    localparam int N_I   = lanes_at(NUM_IN, i);
    localparam int N_O   = lanes_at(NUM_IN, i + 1);
    localparam int OFF_I = stage_offset(NUM_IN, SUM_W, i);
    localparam int OFF_O = stage_offset(NUM_IN, SUM_W, i + 1);

    student_fir_sum_tree_level #(
      .N_IN  (N_I),
      .W     (SUM_W),
      .N_OUT (N_O)
    ) u_level (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (stage_valid[i]),
      .data_i  (stage_data[OFF_I +: N_I*SUM_W]),
      .valid_o (stage_valid[i+1]),
      .data_o  (stage_data[OFF_O +: N_O*SUM_W])
    );
  end

  assign tree_sum   = stage_data[SUM_OFF +: SUM_W];
  assign tree_valid = stage_valid[L];

  // One guard bit above the sum absorbs the rounding increment.
  always_comb begin
    shamt   = (int'(shift_i) > MAX_SH) ? 6'(MAX_SH) : {1'b0, shift_i};
    ext     = EXT_W'(tree_sum);
    rnd     = (round_en_i && (shamt != 6'd0)) ? (EXT_W'(1) << (shamt - 6'd1)) : '0;
    shifted = (ext + rnd) >>> shamt;
    wide    = CMP_W'(shifted);
    ovf_hit = (wide > CMP_MAX) || (wide < CMP_MIN);
    y_next  = wide[OUT_WIDTH-1:0];
    if (ovf_hit && sat_en_i) y_next = (wide > CMP_MAX) ? SAT_MAX : SAT_MIN;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_valid_o <= 1'b0;
      y_o       <= '0;
      ovf_o     <= 1'b0;
    end else begin
      y_valid_o <= tree_valid;
      if (tree_valid) y_o <= y_next;
      if (clear_i)                     ovf_o <= 1'b0;
      else if (tree_valid && ovf_hit)  ovf_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_student_fir_sum_tree.sv
// tb/tb_student_fir_sum_tree.sv - self-checking bench for student_fir_sum_tree
module tb_student_fir_sum_tree;

  localparam int TO    = 8;
  localparam int LAT_A = 4;
  localparam int LAT_B = 5;

  typedef struct {
    longint sum;
    int     due;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a_valid;
  logic [63:0] a_data;
  logic [4:0]  a_shift;
  logic        a_round, a_sat, a_clear;
  logic        a_yv, a_ovf, a_err, a_busy;
  logic [15:0] a_y;
  logic [4:0]  b_valid;
  logic [79:0] b_data;
  logic [4:0]  b_shift;
  logic        b_round, b_sat, b_clear;
  logic        b_yv, b_ovf, b_err, b_busy;
  logic [15:0] b_y;

  int tests = 0;
  int fails = 0;

  bit [3:0]           m_pend = '0;
  int                 m_hold[4];
  int                 m_age = 0;
  bit                 m_err = 0, m_ovf = 0, m_yv = 0;
  logic signed [15:0] m_y = '0;
  int                 m_n = 0;
  frame_t             m_q[$];

  always #5 clk = ~clk;

  student_fir_sum_tree #(.NUM_IN(4), .IN_WIDTH(16), .OUT_WIDTH(16), .TIMEOUT(TO)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .lane_valid_i(a_valid), .lane_data_i(a_data),
    .shift_i(a_shift), .round_en_i(a_round), .sat_en_i(a_sat), .clear_i(a_clear),
    .y_valid_o(a_yv), .y_o(a_y), .ovf_o(a_ovf), .lane_err_o(a_err), .busy_o(a_busy)
  );

  student_fir_sum_tree #(.NUM_IN(5), .IN_WIDTH(16), .OUT_WIDTH(16), .TIMEOUT(TO)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .lane_valid_i(b_valid), .lane_data_i(b_data),
    .shift_i(b_shift), .round_en_i(b_round), .sat_en_i(b_sat), .clear_i(b_clear),
    .y_valid_o(b_yv), .y_o(b_y), .ovf_o(b_ovf), .lane_err_o(b_err), .busy_o(b_busy)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int lane_val(input int i);
    return int'($signed(a_data[i*16 +: 16]));
  endfunction

  function automatic logic [63:0] pack4(input int d0, input int d1, input int d2, input int d3);
    return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_age  = 0;
    m_err  = 0;
    m_ovf  = 0;
    m_yv   = 0;
    m_y    = '0;
    m_q.delete();
  endtask

  // Output arithmetic straight from the rules: clamp shift, round half up, shift, range-check.
  task automatic model_out(input longint s);
    int     sh;
    longint v;
    sh = (int'(a_shift) > 17) ? 17 : int'(a_shift);
    v  = s;
    if (a_round && sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    m_yv = 1;
    if (v > 32767 || v < -32768) begin
      m_ovf = 1;
      m_y   = a_sat ? ((v > 0) ? 16'h7FFF : 16'h8000) : 16'(v);
    end else begin
      m_y = 16'(v);
    end
  endtask

  task automatic model_commit();
    bit     comp, dup_any, was_coll;
    longint s;
    frame_t f;
    m_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_yv = 0;
    if (m_q.size() > 0 && m_q[0].due == m_n) begin
      f = m_q.pop_front();
      model_out(f.sum);
    end
    comp     = 1;
    dup_any  = 0;
    was_coll = (m_pend != 0);
    for (int i = 0; i < 4; i++) begin
      if (!m_pend[i] && !a_valid[i]) comp = 0;
      if (m_pend[i] && a_valid[i]) dup_any = 1;
    end
    if (comp) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += m_pend[i] ? m_hold[i] : lane_val(i);
      m_q.push_back('{sum: s, due: m_n + LAT_A - 1});
    end
    if (a_clear) begin
      m_pend = '0; m_age = 0; m_err = 0; m_ovf = 0;
    end else if (comp) begin
      m_pend = '0; m_age = 0;
      if (dup_any) m_err = 1;
    end else if (was_coll && m_age + 1 == TO) begin
      m_pend = '0; m_age = 0; m_err = 1;
    end else begin
      if (dup_any) m_err = 1;
      for (int i = 0; i < 4; i++) begin
        if (a_valid[i] && !m_pend[i]) begin
          m_hold[i] = lane_val(i);
          m_pend[i] = 1;
        end
      end
      m_age = was_coll ? m_age + 1 : 0;
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_y_valid", a_yv, m_yv);
    chk("cmp_y", $signed(a_y), m_y);
    chk("cmp_ovf", a_ovf, m_ovf);
    chk("cmp_lane_err", a_err, m_err);
    chk("cmp_busy", a_busy, m_pend != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic clear_a();
    a_clear = 1;
    step();
    a_clear = 0;
  endtask

  task automatic frame_a(input string name, input logic [63:0] data, input int exp_y, input bit exp_ovf);
    int                 pulses, lat;
    logic signed [15:0] got;
    pulses = 0; lat = 0; got = '0;
    a_valid = 4'hF;
    a_data  = data;
    for (int i = 1; i <= LAT_A + 3; i++) begin
      step();
      if (i == 1) a_valid = 4'h0;
      if (a_yv) begin
        pulses++;
        if (lat == 0) begin lat = i; got = a_y; end
      end
    end
    chk({name, "_pulses"}, pulses, 1);
    chk({name, "_latency"}, lat, LAT_A);
    chk({name, "_y"}, got, exp_y);
    chk({name, "_ovf"}, a_ovf, exp_ovf);
  endtask

  initial begin
    int order[5] = '{4, 2, 0, 3, 1};
    int pulses, lat;
    logic signed [15:0] got;

    rst_n = 0;
    a_valid = '0; a_data = '0; a_shift = '0; a_round = 0; a_sat = 1; a_clear = 0;
    b_valid = '0; b_data = '0; b_shift = '0; b_round = 0; b_sat = 1; b_clear = 0;
    step();
    step();
    chk("reset_a_y", $signed(a_y), 0);
    chk("reset_a_flags", {a_yv, a_ovf, a_err, a_busy}, 0);
    chk("reset_b_flags", {b_yv, b_ovf, b_err, b_busy, b_y}, 0);
    rst_n = 1;
    step();

    frame_a("same_cycle_sum", pack4(10, 20, -5, 7), 32, 0);

    frame_a("sat_high", pack4(32767, 32767, 32767, 32767), 32767, 1);
    clear_a();
    chk("clear_ovf", a_ovf, 0);
    a_sat = 0;
    frame_a("wrap_high", pack4(32767, 32767, 32767, 32767), -4, 1);
    clear_a();

    a_shift = 2; a_round = 1;
    frame_a("round_pos", pack4(6, 0, 0, 0), 2, 0);
    a_round = 0;
    frame_a("trunc_pos", pack4(6, 0, 0, 0), 1, 0);
    a_round = 1;
    frame_a("round_neg", pack4(-6, 0, 0, 0), -1, 0);
    a_shift = 31; a_round = 0;
    frame_a("shift_clamp_neg", pack4(-20000, -20000, -20000, -20000), -1, 0);
    frame_a("shift_clamp_pos", pack4(20000, 20000, 20000, 20000), 0, 0);
    a_shift = 0;

    a_valid = 4'h1; a_data = pack4(11, 0, 0, 0);
    step();
    a_valid = 4'h0;
    step();
    a_valid = 4'h1; a_data = pack4(99, 0, 0, 0);
    step();
    chk("dup_err", a_err, 1);
    frame_a("dup_keeps_first", pack4(55, 1, 2, 3), 17, 0);
    clear_a();

    a_valid = 4'h7; a_data = pack4(5, 5, 5, 0);
    step();
    a_valid = 4'h0;
    repeat (7) step();
    chk("timeout_not_yet_err", a_err, 0);
    chk("timeout_not_yet_busy", a_busy, 1);
    step();
    chk("timeout_err", a_err, 1);
    chk("timeout_busy", a_busy, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_yv) pulses++;
    end
    chk("timeout_no_pulse", pulses, 0);
    frame_a("after_timeout", pack4(1, 1, 1, 1), 4, 0);

    for (int k = 0; k < 5; k++) begin
      b_valid = 5'(1 << order[k]);
      b_data[order[k]*16 +: 16] = 16'(order[k] + 1);
      if (k < 4) begin
        step();
        chk("b_busy_collect", b_busy, 1);
      end
    end
    pulses = 0; lat = 0; got = '0;
    for (int i = 1; i <= LAT_B + 3; i++) begin
      step();
      if (i == 1) begin
        b_valid = '0;
        chk("b_busy_done", b_busy, 0);
      end
      if (b_yv) begin
        pulses++;
        if (lat == 0) begin lat = i; got = b_y; end
      end
    end
    chk("b_pulses", pulses, 1);
    chk("b_latency", lat, LAT_B);
    chk("b_y", got, 15);

    for (int i = 0; i < 6; i++) begin
      a_valid = 4'hF;
      a_data  = {$urandom(), $urandom()};
      if (i >= 3) begin
        rst_n = 0;
        model_reset();
      end
      step();
    end
    a_valid = 4'h0;
    rst_n = 1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_yv) pulses++;
    end
    chk("reset_mid_no_pulse", pulses, 0);
    chk("reset_mid_outputs", {a_y, a_ovf, a_err, a_busy}, 0);

    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        a_valid[i] = ($urandom_range(0, 99) < 35);
        if ($urandom_range(0, 3) == 0) a_data[i*16 +: 16] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        else                           a_data[i*16 +: 16] = 16'($urandom());
      end
      if ($urandom_range(0, 7) == 0) a_valid = 4'hF;
      a_shift = 5'($urandom_range(0, 20));
      a_round = 1'($urandom());
      a_sat   = 1'($urandom());
      a_clear = ($urandom_range(0, 63) == 0);
      step();
    end
    a_valid = '0;
    a_clear = 0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
